// File: rtl/ext_pipe_if.sv
// Request/result handshake bundle for ext_pipe: decode-side request, ALU-side result,
// and the sticky illegal-mode flag with its clear.
interface ext_pipe_if #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [2:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              err;
    logic              err_clr;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_tag, err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_tag, err
    );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate-extension unit with one-cycle latency and tag pass-through.
// Define EXT_PIPE_SKID_EN for a 2-entry buffer with a registered in_ready.
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input logic       clk,
    input logic       rst_n,
    ext_pipe_if.slave bus
);
    localparam int unsigned PadW = DATA_W - IMM_W;

    localparam logic [2:0] ModeSext    = 3'd0;
    localparam logic [2:0] ModeZext    = 3'd1;
    localparam logic [2:0] ModeUpper   = 3'd2;
    localparam logic [2:0] ModeSextSl2 = 3'd3;
    localparam logic [2:0] ModeOnes    = 3'd4;

    logic [DATA_W-1:0] sext_val;
    logic [DATA_W-1:0] ext_data;
    logic              illegal;
    logic              accept;
    logic              err_q;

    always_comb begin
        sext_val = {{PadW{bus.in_imm[IMM_W-1]}}, bus.in_imm};
        ext_data = '0;
        illegal  = 1'b0;
        case (bus.in_mode)
            ModeSext:    ext_data = sext_val;
            ModeZext:    ext_data = {{PadW{1'b0}}, bus.in_imm};
            ModeUpper:   ext_data = {bus.in_imm, {PadW{1'b0}}};
            ModeSextSl2: ext_data = sext_val << 2;
            ModeOnes:    ext_data = {{PadW{1'b1}}, bus.in_imm};
            default:     illegal  = 1'b1;
        endcase
    end

    // Set on an illegal acceptance beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && illegal) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.err = err_q;

`ifdef EXT_PIPE_SKID_EN
    logic [1:0]        cnt_q, cnt_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [TAG_W-1:0]  tag0_q, tag0_d, tag1_q, tag1_d;
    logic              pop;

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = (cnt_q != 2'd0) && bus.out_ready;

    // Slot 0 is always the head; slot 1 only fills behind a stalled head.
    always_comb begin
        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        case ({accept, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = ext_data;
                    tag0_d  = bus.in_tag;
                end else begin
                    data1_d = ext_data;
                    tag1_d  = bus.in_tag;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                tag0_d  = tag1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with exactly one entry held.
                data0_d = ext_data;
                tag0_d  = bus.in_tag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            data0_q    <= '0;
            data1_q    <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = data0_q;
    assign bus.out_tag   = tag0_q;
`else
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;
    logic              in_ready;

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= ext_data;
            tag_q   <= bus.in_tag;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
`endif
endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: expected results are queued at acceptance and
// checked in order when each result is consumed.
module tb_ext_pipe;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;
`ifdef EXT_PIPE_SKID_EN
    localparam int HoldMax = 2;
`else
    localparam int HoldMax = 1;
`endif
    localparam logic [2:0]  VMode [3] = '{3'd0, 3'd2, 3'd3};
    localparam logic [15:0] VExp  [3] = '{16'hF800, 16'h8000, 16'hE000};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ext_pipe_if #(.IMM_W(16), .DATA_W(DW), .TAG_W(TW)) bus ();
    ext_pipe_if #(.IMM_W(12), .DATA_W(16), .TAG_W(TW)) bus_v ();

    ext_pipe #(.IMM_W(16), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ext_pipe #(.IMM_W(12), .DATA_W(16), .TAG_W(TW)) dut_v (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_v)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [DW+TW-1:0] exp_q [$];
    logic             hold_prev = 1'b0;
    logic [DW+TW-1:0] hold_val;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Consumer side: in-order scoreboard plus output stability under stall.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("hold_stable", 64'({bus.out_valid, bus.out_data, bus.out_tag}),
                    64'({1'b1, hold_val}));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0)
                    chk("out_without_request", 64'(exp_q.size()), 64'd1);
                else
                    chk("out_data_tag", 64'({bus.out_data, bus.out_tag}), 64'(exp_q.pop_front()));
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_val  = {bus.out_data, bus.out_tag};
        end
    end

    task automatic send(input logic [15:0] imm, input logic [2:0] mode, input logic [3:0] tag,
                        input logic [31:0] exp_data);
        bit done = 1'b0;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({exp_data, tag});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic stream(input int first, input int n, input int stall, input bit tput);
        int k   = 0;
        int cyc = 0;
        bus.out_ready = (stall == 0);
        while (k < n && cyc < 100) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'(32'h1000 + 32'(first + k));
            bus.in_mode  = 3'd1;
            bus.in_tag   = 4'(first + k);
            @(negedge clk);
            if (tput) begin
                chk("tput_in_ready", 64'(bus.in_ready), 64'd1);
                if (cyc > 0) chk("tput_out_valid", 64'(bus.out_valid), 64'd1);
            end
            if (bus.in_ready) begin
                exp_q.push_back({32'h1000 + 32'(first + k), 4'(first + k)});
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == stall) begin
                chk("stall_accepted", 64'(k), 64'(HoldMax));
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        chk("stream_accepted", 64'(k), 64'(n));
        if (tput) begin
            @(negedge clk);
            chk("tput_last_valid", 64'(bus.out_valid), 64'd1);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_imm      = '0;
        bus.in_mode     = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
        bus.err_clr     = 1'b0;
        bus_v.in_valid  = 1'b0;
        bus_v.in_imm    = 12'h800;
        bus_v.in_mode   = '0;
        bus_v.in_tag    = '0;
        bus_v.out_ready = 1'b1;
        bus_v.err_clr   = 1'b0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        bus.out_ready = 1'b1;
        send(16'h8001, 3'd0, 4'd0, 32'hFFFF8001);
        send(16'h8001, 3'd1, 4'd1, 32'h00008001);
        send(16'h8001, 3'd2, 4'd2, 32'h80010000);
        send(16'h8001, 3'd3, 4'd3, 32'hFFFE0004);
        send(16'h8001, 3'd4, 4'd4, 32'hFFFF8001);
        send(16'h7FFF, 3'd4, 4'd5, 32'hFFFF7FFF);
        drain();
        chk("err_after_legal", 64'(bus.err), 64'd0);

        stream(1, 6, 5, 1'b0);
        drain();

        stream(16, 20, 0, 1'b1);
        drain();

        send(16'h1234, 3'd6, 4'd3, 32'h0);
        @(negedge clk);
        chk("err_set", 64'(bus.err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(bus.err), 64'd1);
        bus.err_clr = 1'b1;
        send(16'h0001, 3'd7, 4'd4, 32'h0);
        bus.err_clr = 1'b0;
        chk("err_set_wins", 64'(bus.err), 64'd1);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        chk("err_cleared", 64'(bus.err), 64'd0);
        drain();

        // Fill the output stage under stall, then reset between edges.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0005;
        bus.in_mode   = 3'd5;
        bus.in_tag    = 4'd9;
        @(negedge clk);
        if (bus.in_ready) exp_q.push_back({32'h0, 4'd9});
        @(posedge clk);
        #1;
        bus.in_imm  = 16'h00AB;
        bus.in_mode = 3'd1;
        bus.in_tag  = 4'd10;
        @(negedge clk);
        if (bus.in_ready) exp_q.push_back({32'h0000_00AB, 4'd10});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("pre_rst_err", 64'(bus.err), 64'd1);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_err", 64'(bus.err), 64'd0);
        chk("midrst_out_data", 64'(bus.out_data), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_stale", 64'(bus.out_valid), 64'd0);
        end

        for (int i = 0; i < 3; i++) begin
            bus_v.in_mode  = VMode[i];
            bus_v.in_tag   = 4'(i);
            bus_v.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus_v.in_valid = 1'b0;
            @(negedge clk);
            chk("v_out_valid", 64'(bus_v.out_valid), 64'd1);
            chk("v_out_data", 64'(bus_v.out_data), 64'(VExp[i]));
            chk("v_out_tag", 64'(bus_v.out_tag), 64'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate-extension unit for the datapath. Takes an IMM_W-bit immediate plus a 3-bit mode and produces a DATA_W-bit extended operand through a valid/ready handshake, with registered output and an optional 2-entry skid buffer for full throughput under backpressure. It sits between the decode stage and the ALU/branch-target operand muxes and carries an opaque tag so downstream stages can match results to instructions.

## Interface
Parameters:
- IMM_W, 16, immediate width; legal range 2..DATA_W-1
- DATA_W, 32, output width
- TAG_W, 4, width of the pass-through tag; legal range 1 or more

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_imm  in  IMM_W  immediate
- in_mode  in  3  extension mode
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  extended value
- out_tag  out  TAG_W  tag of the result
- err  out  1  sticky illegal-mode flag
- err_clr  in  1  clears err

## Operation
- Request accepted when in_valid && in_ready. Result leaves when out_valid && out_ready.
- Mode encoding, all arithmetic modulo 2^DATA_W:
  - 0 SEXT: imm sign-extended to DATA_W.
  - 1 ZEXT: imm zero-extended.
  - 2 UPPER: imm placed in bits [DATA_W-1 : DATA_W-IMM_W], low bits zero.
  - 3 SEXT_SL2: SEXT value shifted left by 2. The top two bits are dropped.
  - 4 ONES: imm with the upper DATA_W-IMM_W bits forced to 1.
  - 5..7 illegal: out_data = 0, request still completes normally with its tag, and err is set on acceptance.
- err is sticky. err_clr clears it the next cycle. If err_clr and an illegal-mode acceptance occur in the same cycle, the set wins and err = 1.
- Results leave in acceptance order. No request is dropped or duplicated.

## Timing
- Reset: all of out_valid, out_data, out_tag and err go to 0. in_ready is 1 once rst_n is deasserted. Both buffer entries are emptied. In-flight data is discarded when rst_n is asserted mid-operation.
- Latency: 1 cycle. An input accepted at edge N is presented with out_valid = 1 after edge N.
- Output stability: while out_valid && !out_ready, out_data and out_tag hold stable.
- Throughput: 1 result per cycle while out_ready = 1.
- Simultaneous accept and drain on a full output stage: the new result replaces the drained one with no bubble.
- No combinational path from in_valid or in_imm to out_*. The only combinational path to in_ready is the one stated under Configuration.

## Configuration
- EXT_PIPE_SKID_EN defined: a 2-entry buffer is used.
  - in_ready is a pure register output: in_ready = 1 iff fewer than 2 entries are held.
  - Up to 2 results are held while out_ready = 0.
  - in_ready deasserts the cycle after the second entry fills.
  - Entry occupancy runs 0, 1, 2. Moving from 2 to 1 on a drain reasserts in_ready on the next edge.
- EXT_PIPE_SKID_EN undefined: a single output register is used.
  - in_ready = !out_valid || out_ready, which is combinational from out_ready.
  - At most 1 result is held.
- Function, ordering, latency and err behaviour are identical in both builds.

## Test plan
- Mode sweep, default params. in_imm = 16'h8001 in modes 0/1/2/3/4 → 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'hFFFF8001. Then imm = 16'h7FFF in mode 4 → 32'hFFFF7FFF.
- Backpressure:
  - Stream tags 1..6 with out_ready = 0 for 5 cycles, then 1.
  - Skid build: accepts exactly 2, then in_ready = 0.
  - Non-skid build: accepts 1.
  - Both builds: all 6 tags emerge in order, with no loss and no duplicates.
- Full throughput: in_valid = out_ready = 1 for 20 cycles → 20 results in 20 consecutive cycles after the first-cycle latency.
- Illegal mode: mode 6 with tag 3 → out_data = 0, out_tag = 3, err = 1 and sticky. Assert err_clr in the same cycle as another mode-7 acceptance → err stays 1. A later err_clr alone → err = 0.
- Reset mid-operation: hold 2 entries, pull rst_n low asynchronously between edges → out_valid and err drop immediately, in_ready = 1 after release, and no stale result appears.
- Parameter variant IMM_W = 12, DATA_W = 16. imm = 12'h800 in modes 0/2/3 → 16'hF800, 16'h8000, 16'hE000.
